// File: rtl/ddr3_phy_pkg.sv
// Shared definitions for the DDR3 PHY read-side training blocks:
// FSM state encoding, default training pattern and counter widths.
package ddr3_phy_pkg;

  localparam int TAP_W    = 8;
  localparam int SLIP_W   = 2;
  localparam int MATCH_W  = 8;
  localparam int SETTLE_W = 4;

  // Burst word the read-leveling sequencer writes before training a lane.
  localparam logic [3:0] DEFAULT_RX_PATTERN = 4'b0011;

  localparam logic [SLIP_W-1:0] SLIP_LAST = '1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_CHECK  = 3'd3,
    ST_SLIP   = 3'd4,
    ST_STEP   = 3'd5,
    ST_DONE_S = 3'd6,
    ST_FAIL_S = 3'd7
  } rx_align_state_e;

endpackage

// File: rtl/ddr3_rx_settle_timer.sv
// Down-counting settle timer: load starts a window of load_val cycles and
// expire is high on the last cycle of that window.
module ddr3_rx_settle_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expire
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         active_q, active_d;

  always_comb begin
    cnt_d    = cnt_q;
    active_d = active_q;
    if (load) begin
      cnt_d    = load_val - 1'b1;
      active_d = 1'b1;
    end else if (active_q) begin
      if (cnt_q == '0) begin
        active_d = 1'b0;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end

  assign expire = active_q && (cnt_q == '0);

endmodule

// File: rtl/ddr3_rx_lane_align.sv
// Trains one 4:1 input IOD lane: bit-slips and steps the delay line until the
// deserialized word matches PATTERN for MATCH_COUNT consecutive words.
module ddr3_rx_lane_align
  import ddr3_phy_pkg::*;
#(
  parameter logic [3:0] PATTERN       = DEFAULT_RX_PATTERN,
  parameter int         MATCH_COUNT   = 16,
  parameter int         SETTLE_CYCLES = 4,
  parameter int         TAP_MAX       = 127
) (
  input  logic              FAB_CLK,
  input  logic              ARST_N,
  input  logic              START,
  input  logic [3:0]        RX_DATA,
  input  logic              DELAY_LINE_OUT_OF_RANGE,
  output logic              RX_BIT_SLIP,
  output logic              DELAY_LINE_MOVE,
  output logic              DELAY_LINE_DIRECTION,
  output logic              DELAY_LINE_LOAD,
  output logic              BUSY,
  output logic              DONE,
  output logic              FAIL,
  output logic [TAP_W-1:0]  LOCKED_TAP,
  output logic [SLIP_W-1:0] SLIP_CNT,
  output logic [3:0]        RX_DATA_Q,
  output logic [2:0]        DBG_STATE
);

  localparam logic [MATCH_W-1:0]  MATCH_TGT  = MATCH_W'(MATCH_COUNT);
  localparam logic [TAP_W-1:0]    TAP_LAST   = TAP_W'(TAP_MAX);
  localparam logic [SETTLE_W-1:0] SETTLE_VAL = SETTLE_W'(SETTLE_CYCLES);

  rx_align_state_e     state_q, state_d;
  logic [TAP_W-1:0]    tap_q, tap_d;
  logic [SLIP_W-1:0]   slip_q, slip_d;
  logic [MATCH_W-1:0]  match_q, match_d;
  logic [TAP_W-1:0]    locked_tap_q, locked_tap_d;
  logic                after_step_q, after_step_d;
  logic [3:0]          rx_data_q;
  logic                settle_load;
  logic                settle_expire;

  ddr3_rx_settle_timer #(
    .W (SETTLE_W)
  ) u_settle_timer (
    .clk      (FAB_CLK),
    .rst_n    (ARST_N),
    .load     (settle_load),
    .load_val (SETTLE_VAL),
    .expire   (settle_expire)
  );

  // The timer is armed on every transition into SETTLE, whatever caused it.
  assign settle_load = (state_d == ST_SETTLE) && (state_q != ST_SETTLE);

  always_comb begin
    state_d      = state_q;
    tap_d        = tap_q;
    slip_d       = slip_q;
    match_d      = match_q;
    locked_tap_d = locked_tap_q;
    after_step_d = after_step_q;
    case (state_q)
      ST_IDLE, ST_DONE_S, ST_FAIL_S: begin
        if (START) begin
          state_d      = ST_LOAD;
          tap_d        = '0;
          slip_d       = '0;
          match_d      = '0;
          locked_tap_d = '0;
        end
      end
      ST_LOAD: begin
        state_d      = ST_SETTLE;
        after_step_d = 1'b0;
      end
      ST_SETTLE: begin
        // Running off the end of the delay line only matters once we moved it.
        if (after_step_q && DELAY_LINE_OUT_OF_RANGE) begin
          state_d = ST_FAIL_S;
        end else if (settle_expire) begin
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (rx_data_q == PATTERN) begin
          match_d = (match_q == '1) ? match_q : match_q + 1'b1;
          if (match_d == MATCH_TGT) begin
            state_d      = ST_DONE_S;
            locked_tap_d = tap_q;
          end
        end else begin
          match_d = '0;
          state_d = (slip_q == SLIP_LAST) ? ST_STEP : ST_SLIP;
        end
      end
      ST_SLIP: begin
        slip_d       = slip_q + 1'b1;
        after_step_d = 1'b0;
        state_d      = ST_SETTLE;
      end
      ST_STEP: begin
        if (tap_q == TAP_LAST) begin
          state_d = ST_FAIL_S;
        end else begin
          tap_d        = tap_q + 1'b1;
          slip_d       = '0;
          after_step_d = 1'b1;
          state_d      = ST_SETTLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge FAB_CLK or negedge ARST_N) begin
    if (!ARST_N) begin
      state_q      <= ST_IDLE;
      tap_q        <= '0;
      slip_q       <= '0;
      match_q      <= '0;
      locked_tap_q <= '0;
      after_step_q <= 1'b0;
      rx_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      tap_q        <= tap_d;
      slip_q       <= slip_d;
      match_q      <= match_d;
      locked_tap_q <= locked_tap_d;
      after_step_q <= after_step_d;
      rx_data_q    <= RX_DATA;
    end
  end

  assign BUSY                 = (state_q == ST_LOAD)  || (state_q == ST_SETTLE) ||
                                (state_q == ST_CHECK) || (state_q == ST_SLIP)   ||
                                (state_q == ST_STEP);
  assign RX_BIT_SLIP          = (state_q == ST_SLIP);
  assign DELAY_LINE_MOVE      = (state_q == ST_STEP) && (tap_q != TAP_LAST);
  assign DELAY_LINE_DIRECTION = BUSY;
  assign DELAY_LINE_LOAD      = (state_q == ST_LOAD);
  assign DONE                 = (state_q == ST_DONE_S);
  assign FAIL                 = (state_q == ST_FAIL_S);
  assign LOCKED_TAP           = locked_tap_q;
  assign SLIP_CNT             = slip_q;
  assign RX_DATA_Q            = rx_data_q;
  assign DBG_STATE            = state_q;

endmodule

// File: tb/tb_ddr3_rx_lane_align.sv
// Directed bench for ddr3_rx_lane_align with a small IOD lane model; expected
// training results are queued per START and checked when DONE/FAIL rises.
module tb_ddr3_rx_lane_align;

  localparam logic [3:0] PAT     = 4'b0011;
  localparam logic [3:0] GARBAGE = 4'b0101;
  localparam int         W       = 52;

  // clock / reset
  logic FAB_CLK = 1'b0;
  logic ARST_N  = 1'b0;
  always #5 FAB_CLK = ~FAB_CLK;

  logic       START = 1'b0;
  logic [3:0] RX_DATA;
  logic       DELAY_LINE_OUT_OF_RANGE;
  logic       RX_BIT_SLIP, DELAY_LINE_MOVE, DELAY_LINE_DIRECTION, DELAY_LINE_LOAD;
  logic       BUSY, DONE, FAIL;
  logic [7:0] LOCKED_TAP;
  logic [1:0] SLIP_CNT;
  logic [3:0] RX_DATA_Q;
  logic [2:0] DBG_STATE;

  ddr3_rx_lane_align dut (
    .FAB_CLK                 (FAB_CLK),
    .ARST_N                  (ARST_N),
    .START                   (START),
    .RX_DATA                 (RX_DATA),
    .DELAY_LINE_OUT_OF_RANGE (DELAY_LINE_OUT_OF_RANGE),
    .RX_BIT_SLIP             (RX_BIT_SLIP),
    .DELAY_LINE_MOVE         (DELAY_LINE_MOVE),
    .DELAY_LINE_DIRECTION    (DELAY_LINE_DIRECTION),
    .DELAY_LINE_LOAD         (DELAY_LINE_LOAD),
    .BUSY                    (BUSY),
    .DONE                    (DONE),
    .FAIL                    (FAIL),
    .LOCKED_TAP              (LOCKED_TAP),
    .SLIP_CNT                (SLIP_CNT),
    .RX_DATA_Q               (RX_DATA_Q),
    .DBG_STATE               (DBG_STATE)
  );

  // IOD lane model
  logic [1:0] m_init_rot  = 2'd0;
  logic       m_slip_sens = 1'b1;
  logic [7:0] m_good_tap  = 8'd0;
  logic [7:0] m_oor_at    = 8'hFF;
  logic       m_corrupt   = 1'b0;
  logic [1:0] m_rot       = 2'd0;
  logic [7:0] m_mv        = 8'd0;
  logic [1:0] m_eff;
  logic [3:0] m_base;

  function automatic logic [3:0] rotl(input logic [3:0] w, input logic [1:0] r);
    logic [3:0] x;
    x = w;
    for (int i = 0; i < int'(r); i++) x = {x[2:0], x[3]};
    return x;
  endfunction

  always_comb begin
    m_eff  = m_init_rot + m_rot;
    m_base = (m_mv >= m_good_tap) ? PAT : GARBAGE;
    if (m_corrupt)        RX_DATA = 4'b1111;
    else if (m_slip_sens) RX_DATA = rotl(m_base, m_eff);
    else                  RX_DATA = m_base;
    DELAY_LINE_OUT_OF_RANGE = (m_mv >= m_oor_at);
  end

  always @(posedge FAB_CLK) begin
    if (DELAY_LINE_LOAD) begin
      m_rot <= 2'd0;
      m_mv  <= 8'd0;
    end else if (RX_BIT_SLIP) begin
      m_rot <= m_rot + 2'd1;
    end else if (DELAY_LINE_MOVE) begin
      m_mv  <= m_mv + 8'd1;
      m_rot <= 2'd0;
    end
  end

  // scoreboard
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
  endtask

  task automatic push_exp(input int lat, input int loads, input int moves, input int slips,
                          input int slip_cnt, input int locked, input bit f, input bit d);
    logic [W-1:0] e;
    e = {16'(lat), 8'(loads), 8'(moves), 8'(slips), 2'(slip_cnt), 8'(locked), f, d};
    exp_q.push_back(e);
  endtask

  // monitor
  int cyc = 0;
  int n_slip = 0, n_move = 0, n_load = 0, n_viol = 0;
  logic prev_busy = 1'b0, prev_term = 1'b0, prev_pulse = 1'b0;

  always begin
    logic [W-1:0] e;
    @(posedge FAB_CLK);
    #1;
    if (!ARST_N) begin
      cyc = 0; n_slip = 0; n_move = 0; n_load = 0; n_viol = 0;
      prev_busy = 1'b0; prev_term = 1'b0; prev_pulse = 1'b0;
    end else begin
      if (START && !prev_busy) begin
        cyc = 1; n_slip = 0; n_move = 0; n_load = 0; n_viol = 0;
      end else begin
        cyc++;
      end
      if (RX_BIT_SLIP)     n_slip++;
      if (DELAY_LINE_MOVE) n_move++;
      if (DELAY_LINE_LOAD) n_load++;
      if ((RX_BIT_SLIP && DELAY_LINE_MOVE) || ((RX_BIT_SLIP || DELAY_LINE_MOVE) && prev_pulse))
        n_viol++;
      prev_pulse = RX_BIT_SLIP || DELAY_LINE_MOVE;
      if ((DONE || FAIL) && !prev_term) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_completion", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("done",         32'(DONE),       32'(e[0]));
          chk("fail",         32'(FAIL),       32'(e[1]));
          chk("locked_tap",   32'(LOCKED_TAP), 32'(e[9:2]));
          chk("slip_cnt",     32'(SLIP_CNT),   32'(e[11:10]));
          chk("slip_pulses",  32'(n_slip),     32'(e[19:12]));
          chk("move_pulses",  32'(n_move),     32'(e[27:20]));
          chk("load_pulses",  32'(n_load),     32'(e[35:28]));
          chk("latency",      32'(cyc),        32'(e[51:36]));
          chk("busy_at_end",  32'(BUSY),       32'd0);
          chk("pulse_spacing", 32'(n_viol),    32'd0);
        end
      end
      prev_term = DONE || FAIL;
      prev_busy = BUSY;
    end
  end

  // driver tasks
  task automatic cfg(input logic [1:0] init_rot, input logic sens,
                     input logic [7:0] good_tap, input logic [7:0] oor_at);
    m_init_rot  = init_rot;
    m_slip_sens = sens;
    m_good_tap  = good_tap;
    m_oor_at    = oor_at;
  endtask

  task automatic pulse_start();
    @(negedge FAB_CLK);
    START = 1'b1;
    @(negedge FAB_CLK);
    START = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 400) begin
      @(negedge FAB_CLK);
      k++;
    end
    if (exp_q.size() != 0) begin
      chk({name, "_timeout"}, 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
    repeat (3) @(negedge FAB_CLK);
  endtask

  function automatic logic [31:0] all_outputs();
    return 32'({RX_BIT_SLIP, DELAY_LINE_MOVE, DELAY_LINE_DIRECTION, DELAY_LINE_LOAD,
                BUSY, DONE, FAIL, LOCKED_TAP, SLIP_CNT, RX_DATA_Q, DBG_STATE});
  endfunction

  initial begin
    repeat (3) @(negedge FAB_CLK);
    chk("reset_outputs", all_outputs(), 32'd0);
    ARST_N = 1'b1;
    repeat (2) @(negedge FAB_CLK);

    // already aligned at the default tap
    cfg(2'd0, 1'b1, 8'd0, 8'hFF);
    push_exp(22, 1, 0, 0, 0, 0, 1'b0, 1'b1);
    pulse_start();
    wait_done("aligned");

    // rotated by two: two slips
    cfg(2'd2, 1'b1, 8'd0, 8'hFF);
    push_exp(34, 1, 0, 2, 2, 0, 1'b0, 1'b1);
    pulse_start();
    wait_done("rotated");

    // garbage until tap 3, with a START issued mid-training that must be ignored
    cfg(2'd0, 1'b1, 8'd3, 8'hFF);
    push_exp(94, 1, 3, 9, 0, 3, 1'b0, 1'b1);
    pulse_start();
    repeat (20) @(negedge FAB_CLK);
    START = 1'b1;
    @(negedge FAB_CLK);
    START = 1'b0;
    wait_done("tap3");

    // delay line out of range after the 5th move
    cfg(2'd0, 1'b1, 8'hFF, 8'd5);
    push_exp(123, 1, 5, 15, 0, 0, 1'b1, 1'b0);
    pulse_start();
    wait_done("out_of_range");

    // one corrupted word after 10 matches
    cfg(2'd0, 1'b0, 8'd0, 8'hFF);
    push_exp(38, 1, 0, 1, 1, 0, 1'b0, 1'b1);
    pulse_start();
    repeat (14) @(negedge FAB_CLK);
    m_corrupt = 1'b1;
    @(negedge FAB_CLK);
    m_corrupt = 1'b0;
    wait_done("corrupt");

    // reset mid-SETTLE, then retrain
    cfg(2'd0, 1'b1, 8'd0, 8'hFF);
    pulse_start();
    repeat (2) @(negedge FAB_CLK);
    ARST_N = 1'b0;
    #1;
    chk("outputs_in_reset", all_outputs(), 32'd0);
    repeat (2) @(negedge FAB_CLK);
    ARST_N = 1'b1;
    repeat (5) @(negedge FAB_CLK);
    chk("no_reload_before_start", 32'(n_load), 32'd0);
    chk("idle_after_reset", 32'(BUSY), 32'd0);
    push_exp(22, 1, 0, 0, 0, 0, 1'b0, 1'b1);
    pulse_start();
    wait_done("retrain");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
